// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: sole driver of the vga_adapter plot port. Arbitrates a
// full-screen menu ROM copy against a solid rectangle fill, generates ROM
// addresses, clips rectangles to the screen and aligns pixels to ROM latency.
module vga_draw_scheduler #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int ADDR_WIDTH      = 15,
    parameter int COLOUR_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    bg_req,
    output logic                    bg_ack,
    output logic                    bg_done,
    input  logic                    rect_req,
    input  logic [7:0]              rect_x,
    input  logic [6:0]              rect_y,
    input  logic [7:0]              rect_w,
    input  logic [6:0]              rect_h,
    input  logic [COLOUR_WIDTH-1:0] rect_colour,
    output logic                    rect_ack,
    output logic                    rect_done,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [COLOUR_WIDTH-1:0] rom_q,
    output logic [7:0]              oX,
    output logic [6:0]              oY,
    output logic [COLOUR_WIDTH-1:0] oColour,
    output logic                    plot,
    output logic                    busy
);

    typedef enum logic [2:0] {IDLE, BG_DRAW, RECT_DRAW, FLUSH, DONE} state_t;

    state_t                  state, state_next;
    logic                    job_bg;
    logic [1:0]              flush_cnt;
    logic [7:0]              cx;
    logic [6:0]              cy;
    logic [7:0]              rx_q, rw_q;
    logic [6:0]              ry_q, rh_q;
    logic [COLOUR_WIDTH-1:0] rc_q;

    logic                    s1_valid, s1_bg;
    logic [7:0]              s1_x;
    logic [6:0]              s1_y;

    logic [8:0]              px;
    logic [7:0]              py;
    logic                    in_screen, rect_empty, bg_last, rect_last, row_end;
    logic [ADDR_WIDTH-1:0]   cy_ext, bg_addr;

    // Pixel coordinates, clipping and counter end conditions
    always_comb begin
        px         = {1'b0, rx_q} + {1'b0, cx};
        py         = {1'b0, ry_q} + {1'b0, cy};
        in_screen  = (px < 9'(X_SCREEN_PIXELS)) && (py < 8'(Y_SCREEN_PIXELS));
        rect_empty = (rw_q == '0) || (rh_q == '0);
        bg_last    = (cx == 8'(X_SCREEN_PIXELS - 1)) && (cy == 7'(Y_SCREEN_PIXELS - 1));
        rect_last  = (cx == rw_q - 8'd1) && (cy == rh_q - 7'd1);
        row_end    = (state == BG_DRAW) ? (cx == 8'(X_SCREEN_PIXELS - 1))
                                        : (cx == rw_q - 8'd1);
        // Row stride of 160 expressed as 128 + 32
        cy_ext     = ADDR_WIDTH'(cy);
        bg_addr    = (cy_ext << 7) + (cy_ext << 5) + ADDR_WIDTH'(cx);
        rom_addr   = (state == BG_DRAW) ? bg_addr : '0;
        busy       = (state != IDLE);
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bg_req)
                    state_next = BG_DRAW;
                else if (rect_req)
                    state_next = RECT_DRAW;
            end
            BG_DRAW:   if (bg_last) state_next = FLUSH;
            RECT_DRAW: if (rect_empty || rect_last) state_next = FLUSH;
            FLUSH:     if (flush_cnt == 2'd1) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register, job capture, counters and ack/done pulses
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            job_bg    <= 1'b0;
            flush_cnt <= '0;
            cx        <= '0;
            cy        <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            rw_q      <= '0;
            rh_q      <= '0;
            rc_q      <= '0;
            bg_ack    <= 1'b0;
            rect_ack  <= 1'b0;
            bg_done   <= 1'b0;
            rect_done <= 1'b0;
        end else begin
            state     <= state_next;
            bg_ack    <= (state == IDLE) && (state_next == BG_DRAW);
            rect_ack  <= (state == IDLE) && (state_next == RECT_DRAW);
            bg_done   <= (state_next == DONE) && job_bg;
            rect_done <= (state_next == DONE) && !job_bg;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : '0;

            if (state == IDLE && state_next != IDLE) begin
                job_bg <= (state_next == BG_DRAW);
                if (state_next == RECT_DRAW) begin
                    rx_q <= rect_x;
                    ry_q <= rect_y;
                    rw_q <= rect_w;
                    rh_q <= rect_h;
                    rc_q <= rect_colour;
                end
            end

            if ((state == BG_DRAW || state == RECT_DRAW) && state_next != FLUSH) begin
                if (row_end) begin
                    cx <= '0;
                    cy <= cy + 7'd1;
                end else begin
                    cx <= cx + 8'd1;
                end
            end else begin
                cx <= '0;
                cy <= '0;
            end
        end
    end

    // Two-stage pixel pipeline: stage 1 waits out the ROM read, stage 2 drives the adapter
    always_ff @(posedge clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_bg    <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            plot     <= 1'b0;
            oX       <= '0;
            oY       <= '0;
            oColour  <= '0;
        end else begin
            s1_valid <= (state == BG_DRAW) ||
                        ((state == RECT_DRAW) && !rect_empty && in_screen);
            s1_bg    <= (state == BG_DRAW);
            s1_x     <= (state == BG_DRAW) ? cx : px[7:0];
            s1_y     <= (state == BG_DRAW) ? cy : py[6:0];
            plot     <= s1_valid;
            if (s1_valid) begin
                oX      <= s1_x;
                oY      <= s1_y;
                oColour <= s1_bg ? rom_q : rc_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb_vga_draw_scheduler: randomized and directed jobs checked cycle by cycle
// against a pixel-list reference model built from the drawing rules.
module tb_vga_draw_scheduler;

    logic       clk = 1'b0;
    logic       Reset;
    logic       bg_req, rect_req;
    logic       bg_ack, bg_done, rect_ack, rect_done;
    logic [7:0] rect_x, rect_w;
    logic [6:0] rect_y, rect_h;
    logic [2:0] rect_colour;
    logic [14:0] rom_addr;
    logic [2:0] rom_q = '0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       plot, busy;

    int errors = 0;
    int checks = 0;
    int last_x = 0, last_y = 0, last_c = 0;

    vga_draw_scheduler #(
        .X_SCREEN_PIXELS(160),
        .Y_SCREEN_PIXELS(120),
        .ADDR_WIDTH     (15),
        .COLOUR_WIDTH   (3)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .bg_req     (bg_req),
        .bg_ack     (bg_ack),
        .bg_done    (bg_done),
        .rect_req   (rect_req),
        .rect_x     (rect_x),
        .rect_y     (rect_y),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .rect_colour(rect_colour),
        .rect_ack   (rect_ack),
        .rect_done  (rect_done),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .oX         (oX),
        .oY         (oY),
        .oColour    (oColour),
        .plot       (plot),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Synchronous menu ROM stand-in: colour is the low three address bits
    always @(posedge clk) rom_q <= rom_addr[2:0];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (time %0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_oX"}, oX, 0);
        check({tag, "_oY"}, oY, 0);
        check({tag, "_oColour"}, oColour, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_acks"}, {bg_ack, rect_ack}, 0);
        check({tag, "_dones"}, {bg_done, rect_done}, 0);
    endtask

    // Runs one job whose request is already driven; returns at the IDLE cycle after done.
    task automatic run_job(input bit is_bg);
        int x0 = rect_x, y0 = rect_y, w = rect_w, h = rect_h, c0 = rect_colour;
        int n, dt, waited;
        bit ep[];
        int ex[], ey[], ec[];

        n  = is_bg ? 160 * 120 : w * h;
        dt = ((n == 0) ? 1 : n) + 2;
        ep = new[dt + 2];
        ex = new[dt + 2];
        ey = new[dt + 2];
        ec = new[dt + 2];
        for (int k = 0; k < n; k++) begin
            int xx, yy;
            if (is_bg) begin
                xx = k % 160;
                yy = k / 160;
            end else begin
                xx = x0 + k % w;
                yy = y0 + k / w;
            end
            ep[k + 2] = (xx < 160) && (yy < 120);
            ex[k + 2] = xx;
            ey[k + 2] = yy;
            ec[k + 2] = is_bg ? (k % 8) : c0;
        end

        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(is_bg ? bg_ack : rect_ack) && waited < 50);
        check(is_bg ? "bg_ack_wait" : "rect_ack_wait", waited, 1);
        check("other_ack_t0", is_bg ? rect_ack : bg_ack, 0);
        check("busy_t0", busy, 1);
        check("rom_addr_t0", rom_addr, 0);
        if (is_bg) bg_req = 1'b0; else rect_req = 1'b0;

        for (int t = 1; t <= dt + 1; t++) begin
            @(negedge clk);
            if (t == 1 && !is_bg) begin
                rect_x      = 8'($urandom);
                rect_y      = 7'($urandom);
                rect_w      = 8'($urandom);
                rect_h      = 7'($urandom);
                rect_colour = 3'($urandom);
            end
            if (t == 1) check("ack_pulse_len", is_bg ? bg_ack : rect_ack, 0);
            check("plot", plot, ep[t]);
            if (ep[t]) begin
                last_x = ex[t];
                last_y = ey[t];
                last_c = ec[t];
            end
            check("oX", oX, last_x);
            check("oY", oY, last_y);
            check("oColour", oColour, last_c);
            check(is_bg ? "bg_done" : "rect_done", is_bg ? bg_done : rect_done, t == dt);
            check("busy", busy, t <= dt);
            if (is_bg)
                check("rom_addr", rom_addr, (t < n) ? t : 0);
            else
                check("rom_addr_rect", rom_addr, 0);
        end
    endtask

    task automatic start_rect(input int x, input int y, input int w, input int h, input int c);
        rect_x      = 8'(x);
        rect_y      = 7'(y);
        rect_w      = 8'(w);
        rect_h      = 7'(h);
        rect_colour = 3'(c);
        rect_req    = 1'b1;
    endtask

    initial begin
        int waited;
        Reset = 1'b1;
        bg_req = 1'b0;
        rect_req = 1'b0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Full background copy
        bg_req = 1'b1;
        run_job(1'b1);

        // Small rectangle
        start_rect(10, 20, 3, 2, 3'b100);
        run_job(1'b0);

        // Simultaneous requests: background first, held rectangle right after
        start_rect(40, 50, 5, 3, 3'b011);
        bg_req = 1'b1;
        run_job(1'b1);
        run_job(1'b0);

        // Clipping at the bottom-right corner
        start_rect(158, 118, 4, 4, 3'b110);
        run_job(1'b0);

        // Zero-width rectangle
        start_rect(30, 30, 0, 5, 3'b001);
        run_job(1'b0);

        // Randomized rectangles, some straddling the screen edges
        for (int i = 0; i < 25; i++) begin
            start_rect($urandom_range(0, 170), $urandom_range(0, 127),
                       $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 7));
            run_job(1'b0);
        end

        // Reset in the middle of a background copy, request still held
        bg_req = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bg_ack && waited < 50);
        check("rst_bg_ack_wait", waited, 1);
        repeat (100) @(negedge clk);
        check("rst_plot_t100", plot, 1);
        Reset = 1'b1;
        @(negedge clk);
        check_all_zero("midjob_reset");
        Reset = 1'b0;
        last_x = 0;
        last_y = 0;
        last_c = 0;
        run_job(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
